// File: rtl/sigmacore_retire_trace_if.sv
`default_nettype none
// ============================================================================
// Module      : sigmacore_retire_trace_if
// Description : Snoop strobes from the core plus the record drain stream.
// Revision    : 1.0 - initial release
// ============================================================================
interface sigmacore_retire_trace_if #(
    parameter int SEQ_W = 16
);
    logic             reg_write;
    logic             mem_write;
    logic [31:0]      pc_in;
    logic [31:0]      instr_in;
    logic [31:0]      wb_data;
    logic [31:0]      st_addr;
    logic [31:0]      st_data;
    logic             out_valid;
    logic             out_ready;
    logic [1:0]       out_kind;
    logic [31:0]      out_pc;
    logic [31:0]      out_tag;
    logic [31:0]      out_value;
    logic [SEQ_W-1:0] out_seq;

    modport master (
        output reg_write, mem_write, pc_in, instr_in, wb_data, st_addr, st_data,
        output out_ready,
        input  out_valid, out_kind, out_pc, out_tag, out_value, out_seq
    );

    modport slave (
        input  reg_write, mem_write, pc_in, instr_in, wb_data, st_addr, st_data,
        input  out_ready,
        output out_valid, out_kind, out_pc, out_tag, out_value, out_seq
    );
endinterface
`default_nettype wire

// File: rtl/sigmacore_retire_trace.sv
`default_nettype none
// ============================================================================
// Module      : sigmacore_retire_trace
// Description : Retire-trace capture; packs WB/STORE events into a FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
module sigmacore_retire_trace #(
    parameter int DEPTH     = 16,
    parameter bit FILTER_X0 = 1'b1,
    parameter int SEQ_W     = 16
) (
    input  wire logic                  clk,
    input  wire logic                  reset,
    input  wire logic                  trace_en,
    sigmacore_retire_trace_if.slave    bus,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       overflow,
    output logic                       protocol_err,
    output logic [15:0]                drop_count
);
    localparam int c_ptr_w = $clog2(DEPTH);
    localparam int c_lvl_w = c_ptr_w + 1;
    localparam int c_rec_w = 2 + 32 + 32 + 32 + SEQ_W;
    localparam logic [c_lvl_w-1:0] c_full_lvl = c_lvl_w'(DEPTH);
    localparam logic [1:0] c_kind_wb = 2'b01;
    localparam logic [1:0] c_kind_st = 2'b10;

    logic [c_rec_w-1:0] r_mem [0:DEPTH-1];
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_lvl_w-1:0] r_level;
    logic [SEQ_W-1:0]   r_seq;
    logic               r_overflow;
    logic               r_protocol_err;
    logic [15:0]        r_drop_count;

    logic [4:0]         w_rd;
    logic               w_wb_evt;
    logic               w_st_evt;
    logic               w_evt;
    logic               w_valid;
    logic               w_pop;
    logic               w_full;
    logic               w_push;
    logic               w_drop;
    logic               w_collide;
    logic [c_rec_w-1:0] w_new_rec;
    logic [c_rec_w-1:0] w_head;
    logic               w_unused_instr;

    assign w_rd           = bus.instr_in[11:7];
    assign w_unused_instr = ^{bus.instr_in[31:12], bus.instr_in[6:0]};

    // A store colliding with a write-back is never captured and never counted as a drop.
    assign w_wb_evt  = trace_en && bus.reg_write && !(FILTER_X0 && (w_rd == 5'd0));
    assign w_st_evt  = trace_en && bus.mem_write && !bus.reg_write;
    assign w_evt     = w_wb_evt || w_st_evt;
    assign w_collide = trace_en && bus.reg_write && bus.mem_write;

    assign w_valid = (r_level != '0);
    assign w_full  = (r_level == c_full_lvl);
    assign w_pop   = w_valid && bus.out_ready;
    assign w_push  = w_evt && (!w_full || w_pop);
    assign w_drop  = w_evt && w_full && !w_pop;

    assign w_new_rec = w_wb_evt ? {c_kind_wb, bus.pc_in, {27'b0, w_rd}, bus.wb_data, r_seq}
                                : {c_kind_st, bus.pc_in, bus.st_addr, bus.st_data, r_seq};

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_new_rec;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr       <= '0;
            r_rd_ptr       <= '0;
            r_level        <= '0;
            r_seq          <= '0;
            r_overflow     <= 1'b0;
            r_protocol_err <= 1'b0;
            r_drop_count   <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
                r_seq    <= r_seq + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
            if (w_drop) begin
                r_overflow <= 1'b1;
                if (r_drop_count != 16'hFFFF) begin
                    r_drop_count <= r_drop_count + 1'b1;
                end
            end
            if (w_collide) begin
                r_protocol_err <= 1'b1;
            end
        end
    end

    // Head entry is zero-masked while empty so reset and idle outputs read as 0.
    assign w_head = w_valid ? r_mem[r_rd_ptr] : '0;

    assign bus.out_valid = w_valid;
    assign bus.out_kind  = w_head[c_rec_w-1 -: 2];
    assign bus.out_pc    = w_head[SEQ_W+95 -: 32];
    assign bus.out_tag   = w_head[SEQ_W+63 -: 32];
    assign bus.out_value = w_head[SEQ_W+31 -: 32];
    assign bus.out_seq   = w_head[SEQ_W-1:0];

    assign level        = r_level;
    assign overflow     = r_overflow;
    assign protocol_err = r_protocol_err;
    assign drop_count   = r_drop_count;
endmodule
`default_nettype wire

// File: tb/tb_sigmacore_retire_trace.sv
`default_nettype none
// ============================================================================
// Module      : tb_sigmacore_retire_trace
// Description : Directed vector table plus overflow/collision/reset sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sigmacore_retire_trace;
    localparam logic [31:0] c_i_x5  = 32'h100012B7;
    localparam logic [31:0] c_i_x6  = 32'h12330313;
    localparam logic [31:0] c_i_x7  = 32'h12338393;
    localparam logic [31:0] c_i_x0  = 32'h00000013;
    localparam logic [31:0] c_i_sw  = 32'hFE732C23;

    logic        clk_tb;
    logic        rst;
    logic        trace_en;
    logic [4:0]  level;
    logic        overflow;
    logic        protocol_err;
    logic [15:0] drop_count;
    int          total;
    int          bad;

    sigmacore_retire_trace_if #(.SEQ_W(16)) bus ();

    sigmacore_retire_trace #(.DEPTH(16), .FILTER_X0(1'b1), .SEQ_W(16)) dut (
        .clk          (clk_tb),
        .reset        (rst),
        .trace_en     (trace_en),
        .bus          (bus.slave),
        .level        (level),
        .overflow     (overflow),
        .protocol_err (protocol_err),
        .drop_count   (drop_count)
    );

    initial clk_tb = 1'b0;
    always #5 clk_tb = ~clk_tb;

    typedef struct {
        logic        rst, en, rw, mw, rdy;
        logic [31:0] pc, instr, wb, sa, sd;
        logic        ev;
        logic [1:0]  ek;
        logic [31:0] epc, etag, eval;
        logic [15:0] eseq;
        logic [4:0]  elvl;
    } vec_t;

    vec_t vecs [11];

    function automatic vec_t mk(logic r, logic en, logic rw, logic mw, logic rdy,
                                logic [31:0] pc, logic [31:0] instr, logic [31:0] wb,
                                logic [31:0] sa, logic [31:0] sd, logic ev, logic [1:0] ek,
                                logic [31:0] epc, logic [31:0] etag, logic [31:0] eval,
                                logic [15:0] eseq, logic [4:0] elvl);
        vec_t v;
        v.rst = r; v.en = en; v.rw = rw; v.mw = mw; v.rdy = rdy;
        v.pc = pc; v.instr = instr; v.wb = wb; v.sa = sa; v.sd = sd;
        v.ev = ev; v.ek = ek; v.epc = epc; v.etag = etag; v.eval = eval;
        v.eseq = eseq; v.elvl = elvl;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_tb);
        #1;
    endtask

    task automatic idle();
        bus.reg_write = 1'b0; bus.mem_write = 1'b0;
    endtask

    task automatic wb_evt(input logic [31:0] pc, input logic [31:0] instr, input logic [31:0] d);
        bus.reg_write = 1'b1; bus.mem_write = 1'b0;
        bus.pc_in = pc; bus.instr_in = instr; bus.wb_data = d;
    endtask

    initial begin
        total = 0; bad = 0;
        rst = 1'b1; trace_en = 1'b1;
        bus.reg_write = 1'b0; bus.mem_write = 1'b0; bus.out_ready = 1'b0;
        bus.pc_in = '0; bus.instr_in = '0; bus.wb_data = '0;
        bus.st_addr = '0; bus.st_data = '0;

        //              rst en rw mw rdy  pc       instr   wb            st_addr       st_data       v  k      epc      etag          eval          seq lvl
        vecs[0]  = mk(0, 1, 1, 0, 0, 32'h0,  c_i_x5, 32'h10001000, 32'h0,        32'h0,        1, 2'b01, 32'h0,  32'h5,        32'h10001000, 0, 1);
        vecs[1]  = mk(1, 1, 0, 0, 0, 32'h0,  c_i_x5, 32'h0,        32'h0,        32'h0,        0, 2'b00, 32'h0,  32'h0,        32'h0,        0, 0);
        vecs[2]  = mk(0, 1, 1, 0, 1, 32'h4,  c_i_x6, 32'h10001123, 32'h0,        32'h0,        1, 2'b01, 32'h4,  32'h6,        32'h10001123, 0, 1);
        vecs[3]  = mk(0, 1, 1, 0, 1, 32'h8,  c_i_x7, 32'h20002123, 32'h0,        32'h0,        1, 2'b01, 32'h8,  32'h7,        32'h20002123, 1, 1);
        vecs[4]  = mk(0, 1, 0, 1, 1, 32'hC,  c_i_sw, 32'h0,        32'h10000FF8, 32'h20002123, 1, 2'b10, 32'hC,  32'h10000FF8, 32'h20002123, 2, 1);
        vecs[5]  = mk(0, 1, 0, 0, 1, 32'h10, c_i_x0, 32'h0,        32'h0,        32'h0,        0, 2'b00, 32'h0,  32'h0,        32'h0,        0, 0);
        vecs[6]  = mk(0, 1, 1, 0, 1, 32'h10, c_i_x0, 32'hDEAD,     32'h0,        32'h0,        0, 2'b00, 32'h0,  32'h0,        32'h0,        0, 0);
        vecs[7]  = mk(0, 1, 1, 0, 0, 32'h14, c_i_x5, 32'h55,       32'h0,        32'h0,        1, 2'b01, 32'h14, 32'h5,        32'h55,       3, 1);
        vecs[8]  = mk(0, 1, 0, 0, 0, 32'h18, c_i_x5, 32'h66,       32'h0,        32'h0,        1, 2'b01, 32'h14, 32'h5,        32'h55,       3, 1);
        vecs[9]  = mk(0, 0, 1, 0, 0, 32'h1C, c_i_x6, 32'h77,       32'h0,        32'h0,        1, 2'b01, 32'h14, 32'h5,        32'h55,       3, 1);
        vecs[10] = mk(0, 1, 0, 0, 1, 32'h20, c_i_x5, 32'h0,        32'h0,        32'h0,        0, 2'b00, 32'h0,  32'h0,        32'h0,        0, 0);

        repeat (3) tick();
        chk("reset out_valid", 32'(bus.out_valid), 32'd0);
        chk("reset level", 32'(level), 32'd0);
        chk("reset out_seq", 32'(bus.out_seq), 32'd0);
        chk("reset flags", {30'd0, overflow, protocol_err}, 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 11; i++) begin
            rst = vecs[i].rst; trace_en = vecs[i].en;
            bus.reg_write = vecs[i].rw; bus.mem_write = vecs[i].mw; bus.out_ready = vecs[i].rdy;
            bus.pc_in = vecs[i].pc; bus.instr_in = vecs[i].instr; bus.wb_data = vecs[i].wb;
            bus.st_addr = vecs[i].sa; bus.st_data = vecs[i].sd;
            tick();
            chk($sformatf("v%0d valid", i), 32'(bus.out_valid), 32'(vecs[i].ev));
            chk($sformatf("v%0d kind", i), 32'(bus.out_kind), 32'(vecs[i].ek));
            chk($sformatf("v%0d pc", i), bus.out_pc, vecs[i].epc);
            chk($sformatf("v%0d tag", i), bus.out_tag, vecs[i].etag);
            chk($sformatf("v%0d value", i), bus.out_value, vecs[i].eval);
            chk($sformatf("v%0d seq", i), 32'(bus.out_seq), 32'(vecs[i].eseq));
            chk($sformatf("v%0d level", i), 32'(level), 32'(vecs[i].elvl));
            chk($sformatf("v%0d drop_count", i), 32'(drop_count), 32'd0);
        end
        rst = 1'b0; trace_en = 1'b1; idle(); bus.out_ready = 1'b0;

        // Overflow: 18 events into a 16-deep FIFO with the consumer stalled.
        rst = 1'b1; tick(); rst = 1'b0;
        for (int i = 0; i < 18; i++) begin
            wb_evt(32'(i * 4), c_i_x5, 32'(i));
            tick();
        end
        idle();
        chk("ovf level", 32'(level), 32'd16);
        chk("ovf drop_count", 32'(drop_count), 32'd2);
        chk("ovf overflow", 32'(overflow), 32'd1);
        chk("ovf head seq", 32'(bus.out_seq), 32'd0);

        // Full with simultaneous push and pop: no drop, level holds.
        wb_evt(32'h100, c_i_x5, 32'hAB);
        bus.out_ready = 1'b1;
        tick();
        idle();
        chk("full pp level", 32'(level), 32'd16);
        chk("full pp drop_count", 32'(drop_count), 32'd2);
        for (int k = 1; k <= 16; k++) begin
            chk($sformatf("drain%0d valid", k), 32'(bus.out_valid), 32'd1);
            chk($sformatf("drain%0d seq", k), 32'(bus.out_seq), 32'(k));
            if (k == 16) begin
                chk("drain last value", bus.out_value, 32'hAB);
                chk("drain last pc", bus.out_pc, 32'h100);
            end else begin
                chk($sformatf("drain%0d value", k), bus.out_value, 32'(k));
            end
            tick();
        end
        chk("drained valid", 32'(bus.out_valid), 32'd0);
        chk("drained level", 32'(level), 32'd0);
        bus.out_ready = 1'b0;

        // Collision: WB wins, store neither captured nor counted as dropped.
        bus.reg_write = 1'b1; bus.mem_write = 1'b1;
        bus.pc_in = 32'h200; bus.instr_in = c_i_x7; bus.wb_data = 32'h77;
        bus.st_addr = 32'h999; bus.st_data = 32'h888;
        tick();
        idle();
        chk("coll level", 32'(level), 32'd1);
        chk("coll kind", 32'(bus.out_kind), 32'd1);
        chk("coll tag", bus.out_tag, 32'd7);
        chk("coll seq", 32'(bus.out_seq), 32'd17);
        chk("coll protocol_err", 32'(protocol_err), 32'd1);
        chk("coll drop_count", 32'(drop_count), 32'd2);
        for (int i = 0; i < 4; i++) begin
            wb_evt(32'(32'h204 + i * 4), c_i_x6, 32'(i));
            tick();
        end
        idle();
        chk("queued level", 32'(level), 32'd5);

        rst = 1'b1; tick(); rst = 1'b0;
        chk("rst valid", 32'(bus.out_valid), 32'd0);
        chk("rst level", 32'(level), 32'd0);
        chk("rst flags", {30'd0, overflow, protocol_err}, 32'd0);
        chk("rst drop_count", 32'(drop_count), 32'd0);
        chk("rst out_pc", bus.out_pc, 32'd0);
        wb_evt(32'h300, c_i_x5, 32'h1234);
        tick();
        idle();
        chk("post rst valid", 32'(bus.out_valid), 32'd1);
        chk("post rst seq", 32'(bus.out_seq), 32'd0);
        chk("post rst value", bus.out_value, 32'h1234);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
